// File: rtl/list_pkg.sv
// Shared types and lookup-interface widths for the sparse nibble MAC sequencer.
package list_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam int COMP_W    = 4;
  localparam int IDX_W     = 3;
  localparam int LK_DATA_W = 17;
endpackage

// File: rtl/list_find_next.sv
// Combinational find-next-set-bit above cur_i, plus the lowest set bit of the mask.
module list_find_next #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] cur_i,
  output logic [IW-1:0] nxt_o,
  output logic          found_o,
  output logic [IW-1:0] low_o
);
  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    low_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_i[k] && (k > int'(cur_i))) begin
        nxt_o   = IW'(k);
        found_o = 1'b1;
      end
      if (mask_i[k]) low_o = IW'(k);
    end
  end
endmodule

// File: rtl/list_mac_sequencer.sv
// Sparse nibble-pair MAC: walks nonzero A x B nibble pairs through the product
// lookup, one pair per cycle, and accumulates the returned partial products.
module list_mac_sequencer
  import list_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = $clog2(NIBBLES*NIBBLES+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*NIBBLES-1:0]     a,
  input  logic [4*NIBBLES-1:0]     b,
  output logic [COMP_W-1:0]        lk_comp1,
  output logic [COMP_W-1:0]        lk_comp2,
  output logic [IDX_W-1:0]         lk_i,
  output logic [IDX_W-1:0]         lk_j,
  input  logic [LK_DATA_W-1:0]     lk_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         result,
  output logic [CNT_W-1:0]         ops
);
  // vld_pipe[0]: pair issued this cycle; vld_pipe[1]: its lookup data is on lk_data.
  localparam int STAGES = 1;

  typedef logic [NIBBLES-1:0][COMP_W-1:0] nib_t;

  state_e               state_q, state_d;
  nib_t                 a_n, b_n, a_q, a_d, b_q, b_d;
  logic [NIBBLES-1:0]   ma_in, mb_in, ma_q, ma_d, mb_q, mb_d, ma_sel, mb_sel;
  logic [IDX_W-1:0]     li_q, li_d, lj_q, lj_d;
  logic [COMP_W-1:0]    c1_q, c1_d, c2_q, c2_d;
  logic [STAGES:0]      vld_pipe_q, vld_pipe_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     ops_q, ops_d;
  logic                 issue, accept;
  logic [IDX_W-1:0]     a_nxt, a_low, b_nxt, b_low;
  logic                 a_fnd, b_fnd;

  function automatic logic [COMP_W-1:0] pick(input nib_t v, input logic [IDX_W-1:0] idx);
    pick = '0;
    for (int k = 0; k < NIBBLES; k++)
      if (IDX_W'(k) == idx) pick = v[k];
  endfunction

  assign a_n = a;
  assign b_n = b;

  always_comb begin
    for (int k = 0; k < NIBBLES; k++) begin
      ma_in[k] = |a_n[k];
      mb_in[k] = |b_n[k];
    end
  end

  // In IDLE the finders see the incoming masks so the first pair is ready at accept.
  assign ma_sel = (state_q == IDLE) ? ma_in : ma_q;
  assign mb_sel = (state_q == IDLE) ? mb_in : mb_q;

  list_find_next #(.N(NIBBLES), .IW(IDX_W)) u_fn_a (
    .mask_i(ma_sel), .cur_i(li_q), .nxt_o(a_nxt), .found_o(a_fnd), .low_o(a_low));
  list_find_next #(.N(NIBBLES), .IW(IDX_W)) u_fn_b (
    .mask_i(mb_sel), .cur_i(lj_q), .nxt_o(b_nxt), .found_o(b_fnd), .low_o(b_low));

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (|ma_in && |mb_in) ? ISSUE : DONE;
      ISSUE: if (!a_fnd && !b_fnd) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;  ma_d = ma_q;  mb_d = mb_q;
    li_d = li_q;  lj_d = lj_q;  c1_d = c1_q;  c2_d = c2_q;
    acc_d = acc_q;  ops_d = ops_q;
    issue = 1'b0;
    if (vld_pipe_q[STAGES]) begin
      acc_d = acc_q + ACC_W'(lk_data);
      ops_d = ops_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: if (accept) begin
        a_d = a_n;  b_d = b_n;  ma_d = ma_in;  mb_d = mb_in;
        acc_d = '0;  ops_d = '0;
        if (|ma_in && |mb_in) begin
          issue = 1'b1;
          li_d  = a_low;  lj_d = b_low;
          c1_d  = pick(a_n, a_low);
          c2_d  = pick(b_n, b_low);
        end
      end
      // j inner, i outer; j wraps to its lowest set bit when i advances.
      ISSUE: if (b_fnd) begin
        issue = 1'b1;
        lj_d  = b_nxt;
        c1_d  = pick(a_q, li_q);
        c2_d  = pick(b_q, b_nxt);
      end else if (a_fnd) begin
        issue = 1'b1;
        li_d  = a_nxt;  lj_d = b_low;
        c1_d  = pick(a_q, a_nxt);
        c2_d  = pick(b_q, b_low);
      end
      default: ;
    endcase
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;  b_q <= '0;  ma_q <= '0;  mb_q <= '0;
      li_q <= '0;  lj_q <= '0;  c1_q <= '0;  c2_q <= '0;
      acc_q <= '0;  ops_q <= '0;  vld_pipe_q <= '0;
    end else begin
      a_q <= a_d;  b_q <= b_d;  ma_q <= ma_d;  mb_q <= mb_d;
      li_q <= li_d;  lj_q <= lj_d;  c1_q <= c1_d;  c2_q <= c2_d;
      acc_q <= acc_d;  ops_q <= ops_d;  vld_pipe_q <= vld_pipe_d;
    end
  end

  assign lk_comp1 = c1_q;
  assign lk_comp2 = c2_q;
  assign lk_i     = li_q;
  assign lk_j     = lj_q;
  assign result   = acc_q;
  assign ops      = ops_q;
endmodule

// File: tb/tb_list_mac_sequencer.sv
// Directed bench for list_mac_sequencer with a registered product-lookup model.
module tb_list_mac_sequencer;
  localparam int NIBBLES = 4;
  localparam int ACC_W   = 24;
  localparam int CNT_W   = $clog2(NIBBLES*NIBBLES+1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [4*NIBBLES-1:0] a = '0, b = '0;
  logic [3:0]           lk_comp1, lk_comp2;
  logic [2:0]           lk_i, lk_j;
  logic [16:0]          lk_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ACC_W-1:0]     result;
  logic [CNT_W-1:0]     ops;

  int checks = 0;
  int failures = 0;
  logic [5:0] log_ij [0:63];
  int lat;

  list_mac_sequencer #(.NIBBLES(NIBBLES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .lk_comp1(lk_comp1), .lk_comp2(lk_comp2), .lk_i(lk_i), .lk_j(lk_j),
    .lk_data(lk_data), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ops(ops));

  always #5 clk = ~clk;

  // Lookup: product of the two nibbles weighted by their positions, one cycle late.
  always @(posedge clk)
    lk_data <= 17'((lk_comp1 * lk_comp2) << (lk_i + lk_j));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one job, wait for out_valid, record the issued (i,j) per cycle.
  task automatic start_and_wait(input string tag, input logic [15:0] ta, input logic [15:0] tb_v);
    @(negedge clk);
    a = ta;  b = tb_v;  in_valid = 1'b1;  out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;  a = 16'hDEAD;  b = 16'hBEEF;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      log_ij[n] = {lk_i, lk_j};
      if (n == 1) chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      if (out_valid) begin lat = n; break; end
    end
    if (lat == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic finish_job(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] lk_before;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ops", 32'(ops), 32'd0);
    chk("rst_lk", {18'd0, lk_comp1, lk_comp2, lk_i, lk_j}, 32'd0);
    @(negedge clk);  rst_n = 1'b1;

    // Zero operand: no lookups, immediate result.
    lk_before = {lk_i, lk_j};
    start_and_wait("zero", 16'h0000, 16'h1234);
    chk("zero_lat", lat, 1);
    chk("zero_result", 32'(result), 32'd0);
    chk("zero_ops", 32'(ops), 32'd0);
    chk("zero_lk_hold", {26'd0, lk_i, lk_j}, {26'd0, lk_before});
    chk("zero_comp_hold", {24'd0, lk_comp1, lk_comp2}, 32'd0);
    finish_job("zero");

    // Single pair.
    start_and_wait("single", 16'h0001, 16'h0001);
    chk("single_lat", lat, 3);
    chk("single_issue", {26'd0, log_ij[1]}, 32'h00);
    chk("single_result", 32'(result), 32'd1);
    chk("single_ops", 32'(ops), 32'd1);
    finish_job("single");

    // Sparse: A nibbles 3 at i=0 and 2 at i=2; B nibble 5 at j=0 -> 15 + (10<<2).
    start_and_wait("sparse", 16'h0203, 16'h0005);
    chk("sparse_lat", lat, 4);
    chk("sparse_issue0", {26'd0, log_ij[1]}, {26'd0, 3'd0, 3'd0});
    chk("sparse_issue1", {26'd0, log_ij[2]}, {26'd0, 3'd2, 3'd0});
    chk("sparse_result", 32'(result), 32'd55);
    chk("sparse_ops", 32'(ops), 32'd2);

    // Backpressure on the sparse result.
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", 32'(result), 32'd55);
      chk("bp_ops", 32'(ops), 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    finish_job("bp");

    // Dense: all 16 pairs in i-outer, j-inner order.
    start_and_wait("dense", 16'hFFFF, 16'hFFFF);
    chk("dense_lat", lat, 18);
    for (int n = 1; n <= 16; n++)
      chk("dense_order", {26'd0, log_ij[n]}, {26'd0, 3'((n-1)/4), 3'((n-1)%4)});
    chk("dense_result", 32'(result), 32'd50625);
    chk("dense_ops", 32'(ops), 32'd16);
    finish_job("dense");

    // Job right after backpressure/dense, then reset mid-ISSUE of a dense job.
    @(negedge clk);
    a = 16'hFFFF;  b = 16'hFFFF;  in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_ops", 32'(ops), 32'd0);
    chk("mid_rst_lk", {18'd0, lk_comp1, lk_comp2, lk_i, lk_j}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);  rst_n = 1'b1;

    start_and_wait("post_rst", 16'h0001, 16'h0002);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_result", 32'(result), 32'd2);
    chk("post_rst_ops", 32'(ops), 32'd1);
    finish_job("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
